// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a byte stream (16-bit word count,
// big-endian 32-bit words, 8-bit additive checksum), writes each word to
// instruction memory and keeps the CPU in reset until a good image is loaded.
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1; in_valid may drop at any time (stall) and the loader then holds
// everything; in_ready never depends on in_valid or in_data.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Largest legal word count; counts above this would wrap the address.
    localparam logic [16:0]     DEPTH   = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic              accept;

    assign accept = in_valid & in_ready;

    // Ready only in byte-consuming states, and never while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                CNT_HI, CNT_LO, DATA, CSUM: in_ready = 1'b1;
                default:                    in_ready = 1'b0;
            endcase
        end
    end

    // State, counters, assembly register and checksum; all cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CNT_HI;
            count_q    <= 16'd0;
            word_idx_q <= '0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            csum_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
        end
    end

    // Next-state logic; every register holds unless a byte is accepted or
    // the single-cycle WRITE state advances the word index.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        case (state_q)
            CNT_HI: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    state_d       = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    if ({1'b0, count_q[15:8], in_data} > DEPTH) begin
                        state_d = ERR;
                    end else if ({count_q[15:8], in_data} == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_d      = {asm_q[23:0], in_data};
                    csum_d     = csum_q + in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + IDX_ONE;
                if (17'(word_idx_q) + 17'd1 == {1'b0, count_q}) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        mem_we    = (state_q == WRITE);
        mem_addr  = word_idx_q[ADDR_W-1:0];
        mem_wdata = asm_q;
        done      = (state_q == DONE);
        error     = (state_q == ERR);
        cpu_reset = (state_q != DONE);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random streams, a
// stream-level reference model producing expected writes and final outcome.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [2:0]        dbg_state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   stim_q[$];
  logic [W-1:0] exp_q[$];
  int           n_accept;
  int           exp_outcome; // 1 = done, 2 = error

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr,data}
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%0h_%0h expected=none", mem_addr, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({mem_addr, mem_wdata} === e) else begin
          errors++;
          $error("FAIL write observed=%0h expected=%0h", {mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  // reference model: decode the stream by its format rules
  task automatic model_stream();
    int n;
    int sum;
    exp_q.delete();
    n = int'(stim_q[0]) * 256 + int'(stim_q[1]);
    if (n > DEPTH) begin
      exp_outcome = 2;
      n_accept    = 2;
      return;
    end
    sum = 0;
    for (int w = 0; w < n; w++) begin
      logic [31:0]       word;
      logic [ADDR_W-1:0] a;
      int                wi;
      word = 32'd0;
      for (int b = 0; b < 4; b++) begin
        word = word * 256 + 32'(stim_q[2 + 4 * w + b]);
        sum  = sum + int'(stim_q[2 + 4 * w + b]);
      end
      wi = w;
      a  = wi[ADDR_W-1:0];
      exp_q.push_back({a, word});
    end
    n_accept    = 2 + 4 * n + 1;
    exp_outcome = (int'(stim_q[2 + 4 * n]) == (sum % 256)) ? 1 : 2;
  endtask

  // driver: optional idle gap, then present the byte until accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_outcome(input string tag);
    check({tag, "_done"}, 64'(done), 64'(exp_outcome == 1));
    check({tag, "_error"}, 64'(error), 64'(exp_outcome == 2));
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(exp_outcome != 1));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_stream(input string tag, input int max_gap);
    model_stream();
    for (int i = 0; i < n_accept; i++) send_byte(stim_q[i], $urandom_range(0, max_gap));
    repeat (2) @(negedge clk);
    check_outcome(tag);
    repeat (4) @(negedge clk);
    check_outcome({tag, "_hold"});
  endtask

  task automatic build_basic(input logic [7:0] cs);
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h00, 8'h00, 8'h00, 8'h0C, cs};
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] sum;
    logic [7:0] b;
    stim_q.delete();
    stim_q.push_back(8'(n >> 8));
    stim_q.push_back(8'(n));
    sum = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stim_q.push_back(b);
      sum = sum + b;
    end
    if (corrupt) sum = sum + 8'($urandom_range(1, 255));
    stim_q.push_back(sum);
  endtask

  initial begin
    // reset state while reset is held from time zero
    #3 check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_cpu_reset", 64'(cpu_reset), 64'd1);

    // two-word image, good checksum, no gaps
    build_basic(8'h39);
    run_stream("basic_good", 0);

    // same image, bad checksum
    do_reset();
    build_basic(8'h38);
    run_stream("basic_bad", 0);

    // word count above memory depth
    do_reset();
    stim_q = '{8'h01, 8'h01, 8'h11, 8'h22};
    run_stream("too_long", 0);

    // empty images
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h00};
    run_stream("empty_good", 0);
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h01};
    run_stream("empty_bad", 0);

    // basic image with random gaps
    do_reset();
    build_basic(8'h39);
    run_stream("basic_gaps", 5);

    // reset after the fifth data byte, then replay
    do_reset();
    build_basic(8'h39);
    model_stream();
    for (int i = 0; i < 7; i++) send_byte(stim_q[i], $urandom_range(0, 3));
    @(negedge clk);
    check("mid_first_word_written", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    do_reset();
    run_stream("replay", 2);

    // random images, some with corrupted checksum
    for (int k = 0; k < 6; k++) begin
      do_reset();
      build_random($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      run_stream("random", 3);
    end

    // full-depth image: last write lands on the top address
    do_reset();
    build_random(DEPTH, 1'b0);
    run_stream("full_depth", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #400000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: byte stream valid.
REQ-005 The module SHALL have port in_data, input, 8 bits: byte stream payload.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the loader accepts the byte this cycle.
REQ-007 The module SHALL have port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-008 The module SHALL have port mem_addr, output, ADDR_W bits: instruction-memory word address.
REQ-009 The module SHALL have port mem_wdata, output, 32 bits: instruction word to write.
REQ-010 The module SHALL have port cpu_reset, output, 1 bit: reset to the CPU, held high until the load completes.
REQ-011 The module SHALL have port done, output, 1 bit: image loaded and checksum good.
REQ-012 The module SHALL have port error, output, 1 bit: load aborted.

Function
REQ-013 A byte SHALL be accepted only on a rising clk edge where in_valid=1 and in_ready=1; in_data SHALL be ignored at all other times.
REQ-014 The stream format SHALL be: word count N as two bytes, MSB first; then 4*N data bytes, each word MSB first; then one checksum byte.
REQ-015 The module SHALL have states CNT_HI, CNT_LO, DATA, WRITE, CSUM, DONE and ERR.
REQ-016 in_ready SHALL be 1 in CNT_HI, CNT_LO, DATA and CSUM, SHALL be 0 in WRITE, DONE and ERR, and SHALL be 0 whenever reset is high.
REQ-017 CNT_HI SHALL go to CNT_LO on acceptance of a byte.
REQ-018 CNT_LO SHALL go, on acceptance of a byte, to ERR if N > 2^ADDR_W, to CSUM if N = 0, and to DATA otherwise.
REQ-019 DATA SHALL shift each accepted byte into a 32-bit assembly register; on the 4th byte of a word it SHALL go to WRITE.
REQ-020 WRITE SHALL last exactly 1 cycle, with mem_we=1, mem_wdata equal to the assembled word, and mem_addr equal to the current word index.
REQ-021 Leaving WRITE, the word index SHALL increment, and the state SHALL go to CSUM if N words have been written and to DATA otherwise.
REQ-022 mem_we SHALL be 0 in every state other than WRITE.
REQ-023 mem_addr SHALL start at 0 and SHALL NOT wrap, because N <= 2^ADDR_W is enforced; for N = 2^ADDR_W the last write SHALL go to address 2^ADDR_W-1.
REQ-024 The checksum SHALL be the 8-bit sum, modulo 256, of all 4*N data bytes; count bytes SHALL be excluded.
REQ-025 On acceptance of the checksum byte in CSUM, the state SHALL go to DONE if the byte equals the running sum and to ERR otherwise.
REQ-026 DONE and ERR SHALL be terminal, left only by reset.
REQ-027 done SHALL be 1 only in DONE, error SHALL be 1 only in ERR, and cpu_reset SHALL be 0 only in DONE.
REQ-028 A stall (in_valid=0) in any accepting state SHALL hold all state, counters and outputs unchanged.
REQ-029 done, error and cpu_reset SHALL be registered, or decoded directly from registered state, with no combinational path from in_valid or in_data.

Reset
REQ-030 Asserting reset SHALL immediately, asynchronously, set: state=CNT_HI; word index, byte counter, assembly register and checksum all 0; mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0 and cpu_reset=1.
REQ-031 Reset asserted mid-load SHALL abandon the partial image, without clearing memory already written; the next load SHALL restart at address 0.

Verification
REQ-032 Stream 00 02, 20 08 00 05, 00 00 00 0C, checksum 39 with in_valid held high -> writes 0x20080005 @0 and 0x0000000C @1, each with a 1-cycle mem_we; then done=1 and cpu_reset=0.
REQ-033 Same stream with checksum 38 -> both words are written, then error=1, done=0, cpu_reset=1 and in_ready=0 thereafter.
REQ-034 Stream 01 01 with ADDR_W=8 (N=257) -> ERR entered right after the second byte, with no mem_we pulse.
REQ-035 Stream 00 00, checksum 00 -> done=1 with no mem_we pulse; stream 00 00, checksum 01 -> error=1.
REQ-036 Random in_valid gaps of 0-5 cycles on REQ-032 -> identical writes, with each byte counted exactly once.
REQ-037 Reset asserted after the 5th data byte, then REQ-032 replayed -> first write at address 0 and final done=1.
